// File: rtl/bram_pkg.sv
// Shared constants and the byte-lane merge helper for the byte-enable block RAM family.
package bram_pkg;

  localparam int RD_FIRST   = 0;
  localparam int WR_FIRST   = 1;
  localparam int COLL_CNT_W = 16;

  // Widest word the merge helper handles; narrower callers zero-extend in and truncate out.
  localparam int MERGE_MAX_W = 64;

  typedef logic [MERGE_MAX_W-1:0]   merge_word_t;
  typedef logic [MERGE_MAX_W/8-1:0] merge_be_t;

  // New bytes where be is set, old bytes elsewhere.
  function automatic merge_word_t merge_be(input merge_word_t old_w,
                                           input merge_word_t new_w,
                                           input merge_be_t   be);
    merge_word_t res;
    res = old_w;
    for (int i = 0; i < MERGE_MAX_W / 8; i++) begin
      if (be[i]) res[i*8 +: 8] = new_w[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/bram_tdp_array.sv
// Bare dual-port storage: two registered read ports and one byte-enable write port sharing port B.
module bram_tdp_array #(
  parameter int DEPTH = 4096,
  parameter int XLEN  = 32,
  parameter int NBYTE = XLEN / 8,
  parameter int WW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             a_en,
  input  logic [WW-1:0]    a_idx,
  output logic [XLEN-1:0]  a_q,
  input  logic             b_en,
  input  logic [WW-1:0]    b_idx,
  input  logic [NBYTE-1:0] b_we,
  input  logic [XLEN-1:0]  b_wdata,
  output logic [XLEN-1:0]  b_q
);

  (* ram_style = "block" *) logic [XLEN-1:0] mem [DEPTH];

  // NOTE: the array and its read registers have no reset; a reset branch would stop block-RAM inference.
  always_ff @(posedge clk) begin
    if (a_en) a_q <= mem[a_idx];
  end

  // A same-address read here sees the old word, since both sides use non-blocking updates.
  always_ff @(posedge clk) begin
    if (b_en) b_q <= mem[b_idx];
    for (int i = 0; i < NBYTE; i++) begin
      if (b_we[i]) mem[b_idx][i*8 +: 8] <= b_wdata[i*8 +: 8];
    end
  end

endmodule

// File: rtl/bram_tdp_byte.sv
// True-dual-port byte-enable RAM: port A instruction fetch, port B load/store with collision tracking.
// Define BRAM_OUT_REG_EN to add an output register stage on both ports (latency 2).
module bram_tdp_byte
  import bram_pkg::*;
#(
  parameter int DEPTH   = 4096,
  parameter int XLEN    = 32,
  parameter int NBYTE   = XLEN / 8,
  parameter int RD_MODE = RD_FIRST,
  parameter int AW      = $clog2(DEPTH * NBYTE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req,
  input  logic [AW-1:0]         a_addr,
  output logic [XLEN-1:0]       a_rdata,
  output logic                  a_rvalid,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [NBYTE-1:0]      b_be,
  input  logic [AW-1:0]         b_addr,
  input  logic [XLEN-1:0]       b_wdata,
  output logic [XLEN-1:0]       b_rdata,
  output logic                  b_rvalid,
  output logic                  misalign,
  output logic [COLL_CNT_W-1:0] coll_cnt
);

  localparam int OFF = $clog2(NBYTE);
  localparam int WW  = AW - OFF;

  logic [WW-1:0]    a_idx;
  logic [WW-1:0]    b_idx;
  logic             b_wr;
  logic [NBYTE-1:0] b_lane_we;
  logic             coll_hit;
  logic             misalign_hit;
  logic             a_addr_unused;

  assign a_idx = a_addr[AW-1:OFF];
  assign b_idx = b_addr[AW-1:OFF];

  // Gating with rst_n keeps a write from landing on an edge that occurs while reset is held.
  assign b_wr         = b_req & b_we & rst_n;
  assign b_lane_we    = b_wr ? b_be : '0;
  assign coll_hit     = a_req & b_wr & (|b_be) & (a_idx == b_idx);
  assign misalign_hit = b_req & (|b_addr[OFF-1:0]);

  // Fetch addresses are word-aligned by construction; the low bits carry no information.
  assign a_addr_unused = ^a_addr[OFF-1:0];

  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;

  bram_tdp_array #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN),
    .NBYTE (NBYTE),
    .WW    (WW)
  ) u_array (
    .clk     (clk),
    .a_en    (a_req),
    .a_idx   (a_idx),
    .a_q     (a_q),
    .b_en    (b_req),
    .b_idx   (b_idx),
    .b_we    (b_lane_we),
    .b_wdata (b_wdata),
    .b_q     (b_q)
  );

  // First pipeline stage: valids, write context for the response mux, sticky flags and counter.
  logic             a_vld1;
  logic             b_vld1;
  logic             a_primed;
  logic             b_primed;
  logic             b_wr_q;
  logic [NBYTE-1:0] b_be_q;
  logic [XLEN-1:0]  b_wdata_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_vld1   <= 1'b0;
      b_vld1   <= 1'b0;
      a_primed <= 1'b0;
      b_primed <= 1'b0;
      b_wr_q   <= 1'b0;
      misalign <= 1'b0;
      coll_cnt <= '0;
    end else begin
      a_vld1 <= a_req;
      b_vld1 <= b_req;
      if (a_req) a_primed <= 1'b1;
      if (b_req) begin
        b_primed <= 1'b1;
        b_wr_q   <= b_we;
      end
      if (misalign_hit) misalign <= 1'b1;
      if (coll_hit && (coll_cnt != '1)) coll_cnt <= coll_cnt + COLL_CNT_W'(1);
    end
  end

  // Datapath copies only matter when b_wr_q is set, which is itself reset.
  always_ff @(posedge clk) begin
    if (b_req) begin
      b_be_q    <= b_be;
      b_wdata_q <= b_wdata;
    end
  end

  logic [XLEN-1:0] b_resp;
  logic [XLEN-1:0] a_data1;
  logic [XLEN-1:0] b_data1;

  // NOTE: every always_comb output gets a default first so no path leaves a latch.
  always_comb begin
    b_resp = b_q;
    if ((RD_MODE == WR_FIRST) && b_wr_q) begin
      b_resp = XLEN'(merge_be(merge_word_t'(b_q), merge_word_t'(b_wdata_q), merge_be_t'(b_be_q)));
    end
    // Until a port has read once its array register is undefined; present the reset value instead.
    a_data1 = a_primed ? a_q : '0;
    b_data1 = b_primed ? b_resp : '0;
  end

`ifdef BRAM_OUT_REG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= a_vld1;
      b_rvalid <= b_vld1;
      if (a_vld1) a_rdata <= a_data1;
      if (b_vld1) b_rdata <= b_data1;
    end
  end
`else
  assign a_rvalid = a_vld1;
  assign b_rvalid = b_vld1;
  assign a_rdata  = a_data1;
  assign b_rdata  = b_data1;
`endif

endmodule

// File: tb/tb_bram_tdp_byte.sv
// Scoreboard bench for bram_tdp_byte: two instances (read-first and write-first) driven in lockstep.
module tb_bram_tdp_byte;

  localparam int DEPTH = 256;
  localparam int XLEN  = 32;
  localparam int NBYTE = 4;
  localparam int AW    = 10;
`ifdef BRAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             a_req = 1'b0;
  logic [AW-1:0]    a_addr = '0;
  logic             b_req = 1'b0;
  logic             b_we = 1'b0;
  logic [NBYTE-1:0] b_be = '0;
  logic [AW-1:0]    b_addr = '0;
  logic [XLEN-1:0]  b_wdata = '0;

  logic [XLEN-1:0] a_rdata0, a_rdata1, b_rdata0, b_rdata1;
  logic            a_rvalid0, a_rvalid1, b_rvalid0, b_rvalid1;
  logic            misalign0, misalign1;
  logic [15:0]     coll_cnt0, coll_cnt1;

  always #5 clk = ~clk;

  bram_tdp_byte #(.DEPTH(DEPTH), .XLEN(XLEN), .RD_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_addr(a_addr), .a_rdata(a_rdata0), .a_rvalid(a_rvalid0),
    .b_req(b_req), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata0), .b_rvalid(b_rvalid0), .misalign(misalign0), .coll_cnt(coll_cnt0)
  );

  bram_tdp_byte #(.DEPTH(DEPTH), .XLEN(XLEN), .RD_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_addr(a_addr), .a_rdata(a_rdata1), .a_rvalid(a_rvalid1),
    .b_req(b_req), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata1), .b_rvalid(b_rvalid1), .misalign(misalign1), .coll_cnt(coll_cnt1)
  );

  typedef struct { logic [31:0] d; int cyc; } exp_a_t;
  typedef struct { logic [31:0] d0; logic [31:0] d1; int cyc; } exp_b_t;

  exp_a_t      qa[$];
  exp_b_t      qb[$];
  logic [31:0] mem_m [DEPTH];
  logic [31:0] last_a = '0, last_b0 = '0, last_b1 = '0;
  logic        mis_m = 1'b0;
  logic [15:0] coll_m = '0;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Words never written hold unknown data; their read responses are not compared.
  task automatic check_d(input string tag, input logic [31:0] act, input logic [31:0] exp);
    if (!$isunknown(exp)) check(tag, act, exp);
  endtask

  function automatic logic [31:0] ref_merge(input logic [31:0] o, input logic [31:0] n,
                                            input logic [3:0] be);
    logic [31:0] r;
    r = o;
    if (be[0]) r[7:0]   = n[7:0];
    if (be[1]) r[15:8]  = n[15:8];
    if (be[2]) r[23:16] = n[23:16];
    if (be[3]) r[31:24] = n[31:24];
    return r;
  endfunction

  task automatic monitor();
    logic exp_av, exp_bv;
    exp_av = (qa.size() != 0) && (qa[0].cyc + LAT == cyc);
    exp_bv = (qb.size() != 0) && (qb[0].cyc + LAT == cyc);
    check("a_rvalid0", 32'(a_rvalid0), 32'(exp_av));
    check("a_rvalid1", 32'(a_rvalid1), 32'(exp_av));
    check("b_rvalid0", 32'(b_rvalid0), 32'(exp_bv));
    check("b_rvalid1", 32'(b_rvalid1), 32'(exp_bv));
    if (exp_av) begin
      exp_a_t e;
      e = qa.pop_front();
      last_a = e.d;
    end
    if (exp_bv) begin
      exp_b_t e;
      e = qb.pop_front();
      last_b0 = e.d0;
      last_b1 = e.d1;
    end
    check_d("a_rdata0", a_rdata0, last_a);
    check_d("a_rdata1", a_rdata1, last_a);
    check_d("b_rdata0", b_rdata0, last_b0);
    check_d("b_rdata1", b_rdata1, last_b1);
    check("misalign0", 32'(misalign0), 32'(mis_m));
    check("misalign1", 32'(misalign1), 32'(mis_m));
    check("coll_cnt0", 32'(coll_cnt0), 32'(coll_m));
    check("coll_cnt1", 32'(coll_cnt1), 32'(coll_m));
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    monitor();
  endtask

  task automatic issue(input logic ar, input logic [AW-1:0] aa,
                       input logic br, input logic bw, input logic [3:0] be,
                       input logic [AW-1:0] ba, input logic [31:0] wd);
    logic [7:0]  wa, wb;
    logic [31:0] old, mrg;
    a_req = ar; a_addr = aa;
    b_req = br; b_we = bw; b_be = be; b_addr = ba; b_wdata = wd;
    wa = aa[AW-1:2];
    wb = ba[AW-1:2];
    if (ar) qa.push_back('{d: mem_m[wa], cyc: cyc});
    if (br) begin
      old = mem_m[wb];
      mrg = bw ? ref_merge(old, wd, be) : old;
      qb.push_back('{d0: old, d1: mrg, cyc: cyc});
      if (ba[1:0] != 2'b00) mis_m = 1'b1;
      if (bw) mem_m[wb] = mrg;
    end
    if (ar && br && bw && (be != 4'h0) && (wa == wb) && (coll_m != 16'hFFFF)) coll_m++;
    cycle();
    a_req = 1'b0;
    b_req = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    #12;
    monitor();
    rst_n = 1'b1;
    idle(2);

    for (int i = 0; i < 16; i++)
      issue(0, '0, 1, 1, 4'hF, AW'(i * 4), (i == 12) ? 32'h1234_5678 : 32'h0);
    idle(LAT);

    // Write then fetch the same word.
    issue(0, '0, 1, 1, 4'hF, 10'h010, 32'hDEAD_BEEF);
    issue(1, 10'h010, 0, 0, 4'h0, '0, '0);
    idle(LAT);

    // Partial byte write and read-back.
    issue(0, '0, 1, 1, 4'b0101, 10'h010, 32'h1122_3344);
    issue(0, '0, 1, 0, 4'h0, 10'h010, '0);
    idle(LAT);
    check("merge_0101", last_b0, 32'hDE22_BE44);

    // Write response: old word in read-first, new word in write-first.
    issue(0, '0, 1, 1, 4'hF, 10'h020, 32'hAAAA_5555);
    idle(LAT);
    check("wr_resp_rf", last_b0, 32'h0);
    check("wr_resp_wf", last_b1, 32'hAAAA_5555);

    // Cross-port collision: fetch sees the old word, then the new one.
    issue(1, 10'h030, 1, 1, 4'hF, 10'h030, 32'hCAFE_F00D);
    issue(1, 10'h030, 0, 0, 4'h0, '0, '0);
    idle(LAT);

    // Not collisions: dual read of one word, and a same-word write with no lanes enabled.
    issue(1, 10'h020, 1, 0, 4'h0, 10'h020, '0);
    issue(1, 10'h020, 1, 1, 4'h0, 10'h020, 32'hFFFF_FFFF);
    // Partial write on a different word while port A fetches elsewhere.
    issue(1, 10'h004, 1, 1, 4'b1010, 10'h008, 32'h5A5A_A5A5);

    // Back-to-back traffic on both ports.
    for (int i = 0; i < 8; i++)
      issue(1, AW'(i * 4), 1, i[0], 4'(i + 3), AW'((15 - i) * 4), $urandom);
    idle(LAT);

    // Misaligned port-B accesses proceed word-aligned; port A low bits are ignored.
    issue(1, 10'h013, 0, 0, 4'h0, '0, '0);
    issue(0, '0, 1, 0, 4'h0, 10'h013, '0);
    issue(0, '0, 1, 1, 4'b0011, 10'h022, 32'h0BAD_CAFE);
    issue(0, '0, 1, 0, 4'h0, 10'h020, '0);
    idle(LAT + 2);

    // Reset while a fetch is in flight; a write presented during reset must not land.
    a_req = 1'b1; a_addr = 10'h010;
    @(posedge clk); #1;
    a_req = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_a_rvalid0", 32'(a_rvalid0), 32'h0);
    check("rst_a_rvalid1", 32'(a_rvalid1), 32'h0);
    check("rst_a_rdata0", a_rdata0, 32'h0);
    check("rst_misalign0", 32'(misalign0), 32'h0);
    check("rst_coll_cnt1", 32'(coll_cnt1), 32'h0);
    b_req = 1'b1; b_we = 1'b1; b_be = 4'hF; b_addr = 10'h010; b_wdata = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    b_req = 1'b0;
    rst_n = 1'b1;
    qa.delete();
    qb.delete();
    last_a = '0; last_b0 = '0; last_b1 = '0;
    mis_m = 1'b0;
    coll_m = '0;
    cyc += 2;
    idle(1);
    issue(1, 10'h010, 1, 0, 4'h0, 10'h020, '0);
    idle(LAT);
    check("mem_kept", last_a, 32'hDE22_BE44);

    // Drive the collision counter into saturation.
    for (int i = 0; i < 65538; i++)
      issue(1, 10'h03C, 1, 1, 4'hF, 10'h03C, $urandom);
    idle(LAT + 1);
    check("coll_sat", 32'(coll_cnt0), 32'h0000_FFFF);
    check("qa_drained", 32'(qa.size()), 32'h0);
    check("qb_drained", 32'(qb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
